fifo_pkt_reader: RTL

//  Read-side consumer of the 32-bit word FIFO. Pops length-prefixed packets from the FIFO read port
//  and emits them as a valid/ready stream with an end-of-packet flag. Sits between the FIFO and

---
 rtl/fifo_pkt_pkg.sv | 16 +
 rtl/fifo_pkt_reader_skid.sv | 62 ++++++
 rtl/fifo_pkt_reader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the FIFO packet reader: FSM states and header layout.
package fifo_pkt_pkg;

   typedef enum logic [1:0] {
      HDR_REQ  = 2'd0,
      HDR_WAIT = 2'd1,
      PAYLOAD  = 2'd2,
      DROP     = 2'd3
   } state_t;

   // Header word: payload length lives in the low bits, upper bits are ignored.
   localparam int HDR_LEN_LSB = 0;
   localparam int HDR_LEN_W   = 16;
   localparam int DEF_MAX_LEN = 64;

endpackage

// File: rtl/fifo_pkt_reader_skid.sv
// Two-entry in-order valid/ready buffer carrying {data,last}.
// Outputs come straight from the head registers; the tail absorbs one extra beat.
module stream_skid2 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   input  logic         i_last,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_last,
   input  logic         i_ready,
   output logic [1:0]   o_occ
);

   logic         r_h_vld, r_t_vld;
   logic         r_h_last, r_t_last;
   logic [W-1:0] r_h_data, r_t_data;
   logic         w_pop;

   assign w_pop   = r_h_vld && i_ready;
   assign o_valid = r_h_vld;
   assign o_data  = r_h_data;
   assign o_last  = r_h_last;
   assign o_occ   = {1'b0, r_h_vld} + {1'b0, r_t_vld};

   // Head refills from tail (if any) or from the incoming beat; tail only fills when head is stuck.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_vld  <= 1'b0;
         r_h_data <= '0;
         r_h_last <= 1'b0;
         r_t_vld  <= 1'b0;
         r_t_data <= '0;
         r_t_last <= 1'b0;
      end else if (!r_h_vld || w_pop) begin
         if (r_t_vld) begin
            r_h_vld  <= 1'b1;
            r_h_data <= r_t_data;
            r_h_last <= r_t_last;
            r_t_vld  <= i_valid;
            if (i_valid) begin
               r_t_data <= i_data;
               r_t_last <= i_last;
            end
         end else begin
            r_h_vld <= i_valid;
            if (i_valid) begin
               r_h_data <= i_data;
               r_h_last <= i_last;
            end
         end
      end else if (i_valid) begin
         r_t_vld  <= 1'b1;
         r_t_data <= i_data;
         r_t_last <= i_last;
      end
   end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Read-side consumer of the word FIFO: parses length-prefixed packets and
// streams payload words out with an end-of-packet flag.
module fifo_pkt_reader
   import fifo_pkt_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter int LEN_W     = HDR_LEN_W,
   parameter int MAX_LEN   = DEF_MAX_LEN,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 fifo_rd_en,
   input  logic                 fifo_empty,
   input  logic [WORD_SIZE-1:0] fifo_data,
   output logic [WORD_SIZE-1:0] m_data,
   output logic                 m_valid,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 pkt_done,
   output logic [CNT_W-1:0]     pkt_count,
   output logic                 err_len,
   input  logic                 err_clr
);

   state_t           r_state, w_next;
   logic [LEN_W-1:0] r_remain;
   logic [LEN_W-1:0] w_len;
   logic             r_pending, r_pend_last, r_armed;
   logic             w_rd_en, w_enq, w_hs, w_too_long, w_credit;
   logic [1:0]       w_occ;
   logic             r_done, r_err;
   logic [CNT_W-1:0] r_count;

   assign w_len      = fifo_data[HDR_LEN_LSB +: LEN_W];
   assign w_too_long = w_len > LEN_W'(MAX_LEN);
   assign w_credit   = (3'(w_occ) + 3'(r_pending)) < 3'd2;
   assign w_hs       = m_valid && m_ready && m_last;
   // Any word in flight while in PAYLOAD was issued in PAYLOAD (HDR_WAIT never issues).
   assign w_enq      = r_pending && (r_state == PAYLOAD);

   assign fifo_rd_en = w_rd_en;
   assign pkt_done   = r_done;
   assign pkt_count  = r_count;
   assign err_len    = r_err;

   // Next-state and read-issue decode.
   always_comb begin
      w_next  = r_state;
      w_rd_en = 1'b0;
      case (r_state)
         HDR_REQ: begin
            if (r_armed && !fifo_empty) begin
               w_rd_en = 1'b1;
               w_next  = HDR_WAIT;
            end
         end
         HDR_WAIT: begin
            if (w_len == '0)     w_next = HDR_REQ;
            else if (w_too_long) w_next = DROP;
            else                 w_next = PAYLOAD;
         end
         PAYLOAD: begin
            w_rd_en = !fifo_empty && (r_remain != '0) && w_credit;
            if ((r_remain == '0) && !r_pending) w_next = HDR_REQ;
         end
         DROP: begin
            w_rd_en = !fifo_empty && (r_remain != '0);
            if ((r_remain == '0) && !r_pending) w_next = HDR_REQ;
         end
         default: w_next = HDR_REQ;
      endcase
   end

   // FSM state, in-flight tracking and remaining payload count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= HDR_REQ;
         r_pending   <= 1'b0;
         r_pend_last <= 1'b0;
         r_remain    <= '0;
         r_armed     <= 1'b0;
      end else begin
         r_armed     <= 1'b1;
         r_state     <= w_next;
         r_pending   <= w_rd_en;
         r_pend_last <= w_rd_en && (r_remain == LEN_W'(1));
         if (r_state == HDR_WAIT) begin
            r_remain <= w_len;
         end else if (w_rd_en && ((r_state == PAYLOAD) || (r_state == DROP))) begin
            r_remain <= r_remain - LEN_W'(1);
         end
      end
   end

   // Packet-done pulse, delivered count and sticky length error (set beats clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done  <= 1'b0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_done <= w_hs;
         if (w_hs) r_count <= r_count + CNT_W'(1);
         if ((r_state == HDR_WAIT) && w_too_long) r_err <= 1'b1;
         else if (err_clr)                        r_err <= 1'b0;
      end
   end

   stream_skid2 #(.W(WORD_SIZE)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_enq),
      .i_data  (fifo_data),
      .i_last  (r_pend_last),
      .o_valid (m_valid),
      .o_data  (m_data),
      .o_last  (m_last),
      .i_ready (m_ready),
      .o_occ   (w_occ)
   );

endmodule
